switch_debounce: RTL

- Multi-channel input conditioner between raw board switches/buttons and the team's combinational gate logic.
- Synchronises each asynchronous pin into the clock domain and filters contact bounce with a per-channel counter FSM.
- Per channel, outputs a clean stable level plus single-cycle rise and fall pulses.
- Downstream gate logic reads the stable levels (sw_level) in place of raw pins.

---
 rtl/switch_debounce_pkg.sv | 13 +
 rtl/debounce_ch.sv | 114 +++++++++++
 rtl/switch_debounce.sv | 29 ++
 3 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared types and constants for the multi-channel switch debouncer.
package switch_debounce_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_LO      = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

endpackage : switch_debounce_pkg

// File: rtl/debounce_ch.sv
// Single-channel conditioner: two-flop synchroniser, qualification FSM and
// counter, registered level plus one-cycle rise/fall pulses.
module debounce_ch
    import switch_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;
    logic             rise_d;
    logic             fall_d;

    // Metastability guard; the FSM only ever looks at sync2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            level <= level_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

    // A single opposite sample in a wait state drops back to the settled state.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state)
            ST_LO: begin
                if (sync2) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_WAIT_HI: begin
                if (!sync2) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!sync2) begin
                    state_d = ST_WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_WAIT_LO: begin
                if (sync2) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

endmodule : debounce_ch

// File: rtl/switch_debounce.sv
// Multi-channel switch/button debouncer: WIDTH independent debounce_ch copies.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (sw_in[i]),
            .level(sw_level[i]),
            .rise (sw_rise[i]),
            .fall (sw_fall[i])
        );
    end

endmodule : switch_debounce
